// File: rtl/word_loader.sv
// word_loader
//
// Accepts a packed word of WORD_LENGTH characters and writes it, one character
// per cycle, into a single-port SRAM starting at base_addr, followed by a NUL
// terminator. A NUL inside the word ends the load early; that write is the
// terminator itself. After the load, the block waits for match_done before it
// accepts the next word.
//
// Optional feature: define WORD_LOADER_STATS_EN to add the 16-bit word_count
// output. It counts completed loads and wraps from 0xFFFF to 0.
//
// Ports
//   blocker_clk   clock, rising edge
//   rst_n         asynchronous active-low reset
//   word_valid    upstream offers a packed word
//   word_ready    high in IDLE only (decoded from state)
//   word          packed word, char 0 in bits [DATA_WIDTH-1:0]
//   base_addr     first SRAM address, sampled when the word is accepted
//   sram_cs/we    high during write cycles only
//   sram_addr     write address (holds its last value when idle)
//   sram_din      write data (holds its last value when idle)
//   load_done     one-cycle pulse after the terminator is written
//   match_done    downstream has finished with the word (used in WAIT only)
//   busy          high in every state except IDLE
//   overflow      sticky: the address wrapped during the current load
//   word_count    (WORD_LOADER_STATS_EN only) number of completed loads
module word_loader #(
   parameter int ADDR_WIDTH  = 4,
   parameter int WORD_LENGTH = 3,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                              blocker_clk,
   input  logic                              rst_n,
   input  logic                              word_valid,
   output logic                              word_ready,
   input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
   input  logic [ADDR_WIDTH-1:0]             base_addr,
   output logic                              sram_cs,
   output logic                              sram_we,
   output logic [ADDR_WIDTH-1:0]             sram_addr,
   output logic [DATA_WIDTH-1:0]             sram_din,
   output logic                              load_done,
   input  logic                              match_done,
   output logic                              busy,
   output logic                              overflow
`ifdef WORD_LOADER_STATS_EN
   ,
   output logic [15:0]                       word_count
`endif
);

   localparam int IDX_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LENGTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      TERM,
      DONE,
      WAIT
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] chars [WORD_LENGTH];
   logic [DATA_WIDTH-1:0] cur_char;
   logic [DATA_WIDTH-1:0] din_last;
   logic [ADDR_WIDTH-1:0] addr;
   logic [IDX_W-1:0]      idx;
   logic                  accept;
   logic                  more_writes;

   assign accept   = word_valid && word_ready;
   assign cur_char = chars[idx];

   // State register
   always_ff @(posedge blocker_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. more_writes marks a WRITE cycle that is followed by
   // another write; only then does the address advance. The address therefore
   // stays on the last written location, and a wrap counts as overflow only
   // when a write really lands on the wrapped address.
   always_comb begin
      state_nxt   = state;
      more_writes = 1'b0;
      case (state)
         IDLE: begin
            if (word_valid) state_nxt = WRITE;
         end
         WRITE: begin
            if (cur_char == '0) begin
               state_nxt = DONE;
            end else if (idx == LAST_IDX) begin
               state_nxt   = TERM;
               more_writes = 1'b1;
            end else begin
               state_nxt   = WRITE;
               more_writes = 1'b1;
            end
         end
         TERM:    state_nxt = DONE;
         DONE:    state_nxt = WAIT;
         WAIT: begin
            if (match_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from state. Reset therefore forces them to their
   // idle values immediately.
   assign word_ready = (state == IDLE);
   assign busy       = (state != IDLE);
   assign load_done  = (state == DONE);
   assign sram_cs    = (state == WRITE) || (state == TERM);
   assign sram_we    = sram_cs;
   assign sram_addr  = addr;
   assign sram_din   = (state == WRITE) ? cur_char :
                       (state == TERM)  ? '0       : din_last;

   // Control and address state
   always_ff @(posedge blocker_clk or negedge rst_n) begin
      if (!rst_n) begin
         addr     <= '0;
         idx      <= '0;
         overflow <= 1'b0;
         din_last <= '0;
      end else begin
         if (accept) begin
            addr     <= base_addr;
            idx      <= '0;
            overflow <= 1'b0;
         end else if (state == WRITE) begin
            idx <= idx + 1'b1;
            if (more_writes) begin
               addr <= addr + 1'b1;
               if (&addr) overflow <= 1'b1;
            end
         end
         if (sram_cs) din_last <= sram_din;
      end
   end

   // Captured word: data only. It is not reset because it is only read after
   // an accept has loaded it.
   always_ff @(posedge blocker_clk) begin
      if (accept) begin
         for (int i = 0; i < WORD_LENGTH; i++) begin
            chars[i] <= word[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef WORD_LOADER_STATS_EN
   always_ff @(posedge blocker_clk or negedge rst_n) begin
      if (!rst_n) begin
         word_count <= '0;
      end else if (state == DONE) begin
         word_count <= word_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_word_loader.sv
// tb_word_loader
//
// Directed bench for word_loader with default parameters (ADDR_WIDTH=4,
// WORD_LENGTH=3, DATA_WIDTH=8). Every expected value is hand-computed. Cycle n
// means the interval after rising edge n, where the accept edge is edge 0.
// Outputs are sampled 1 time unit after the rising edge.
// Build with WORD_LOADER_STATS_EN defined to also exercise word_count.
module tb_word_loader;

   logic        blocker_clk = 1'b0;
   logic        rst_n       = 1'b0;
   logic        word_valid  = 1'b0;
   logic        match_done  = 1'b0;
   logic [23:0] word        = '0;
   logic [3:0]  base_addr   = '0;
   logic        word_ready;
   logic        sram_cs;
   logic        sram_we;
   logic [3:0]  sram_addr;
   logic [7:0]  sram_din;
   logic        load_done;
   logic        busy;
   logic        overflow;
`ifdef WORD_LOADER_STATS_EN
   logic [15:0] word_count;
`endif

   int vectors     = 0;
   int miscompares = 0;

   word_loader dut (
      .blocker_clk (blocker_clk),
      .rst_n       (rst_n),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .word        (word),
      .base_addr   (base_addr),
      .sram_cs     (sram_cs),
      .sram_we     (sram_we),
      .sram_addr   (sram_addr),
      .sram_din    (sram_din),
      .load_done   (load_done),
      .match_done  (match_done),
      .busy        (busy),
      .overflow    (overflow)
`ifdef WORD_LOADER_STATS_EN
      ,
      .word_count  (word_count)
`endif
   );

   always #5 blocker_clk = ~blocker_clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge blocker_clk);
      #1;
   endtask

   // Check one cycle of SRAM-side outputs, then advance to the next cycle.
   task automatic wcyc(input string tag, input logic cs, input logic [3:0] a,
                       input logic [7:0] d, input logic done, input logic ovf);
      chk({tag, ".cs"},   sram_cs,   cs);
      chk({tag, ".we"},   sram_we,   cs);
      chk({tag, ".addr"}, sram_addr, a);
      chk({tag, ".din"},  sram_din,  d);
      chk({tag, ".done"}, load_done, done);
      chk({tag, ".ovf"},  overflow,  ovf);
      step();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".ready"}, word_ready, 1'b1);
      chk({tag, ".cs"},    sram_cs,    1'b0);
      chk({tag, ".we"},    sram_we,    1'b0);
      chk({tag, ".addr"},  sram_addr,  4'h0);
      chk({tag, ".din"},   sram_din,   8'h00);
      chk({tag, ".done"},  load_done,  1'b0);
      chk({tag, ".busy"},  busy,       1'b0);
      chk({tag, ".ovf"},   overflow,   1'b0);
   endtask

   initial begin
      #1;
      chk_reset_vals("por");
      step();
      step();
      rst_n = 1'b1;
      step();

      // "cat" at address 0
      word = 24'h746163; base_addr = 4'd0; word_valid = 1'b1;
      step();
      word_valid = 1'b0;
      wcyc("cat_c1", 1'b1, 4'd0, 8'h63, 1'b0, 1'b0);
      wcyc("cat_c2", 1'b1, 4'd1, 8'h61, 1'b0, 1'b0);
      wcyc("cat_c3", 1'b1, 4'd2, 8'h74, 1'b0, 1'b0);
      wcyc("cat_c4", 1'b1, 4'd3, 8'h00, 1'b0, 1'b0);
      wcyc("cat_c5", 1'b0, 4'd3, 8'h00, 1'b1, 1'b0);
      chk("cat_wait.ready", word_ready, 1'b0);
      chk("cat_wait.busy",  busy,       1'b1);
      match_done = 1'b1;
      step();
      match_done = 1'b0;
      chk("cat_idle.ready", word_ready, 1'b1);
      chk("cat_idle.busy",  busy,       1'b0);

      // "hi": the NUL in char 2 is the terminator, so there is no TERM cycle
      word = 24'h006869; base_addr = 4'd5; word_valid = 1'b1;
      step();
      word_valid = 1'b0;
      wcyc("hi_c1", 1'b1, 4'd5, 8'h69, 1'b0, 1'b0);
      wcyc("hi_c2", 1'b1, 4'd6, 8'h68, 1'b0, 1'b0);
      wcyc("hi_c3", 1'b1, 4'd7, 8'h00, 1'b0, 1'b0);
      wcyc("hi_c4", 1'b0, 4'd7, 8'h00, 1'b1, 1'b0);
      wcyc("hi_c5", 1'b0, 4'd7, 8'h00, 1'b0, 1'b0);
      match_done = 1'b1;
      step();
      match_done = 1'b0;

      // "cat" at 14: the address wraps 15 -> 0
      word = 24'h746163; base_addr = 4'd14; word_valid = 1'b1;
      step();
      word_valid = 1'b0;
      wcyc("wrap_c1", 1'b1, 4'd14, 8'h63, 1'b0, 1'b0);
      wcyc("wrap_c2", 1'b1, 4'd15, 8'h61, 1'b0, 1'b0);
      wcyc("wrap_c3", 1'b1, 4'd0,  8'h74, 1'b0, 1'b1);
      wcyc("wrap_c4", 1'b1, 4'd1,  8'h00, 1'b0, 1'b1);
      wcyc("wrap_c5", 1'b0, 4'd1,  8'h00, 1'b1, 1'b1);
      match_done = 1'b1;
      step();
      match_done = 1'b0;
      chk("wrap_idle.ovf",   overflow,   1'b1);
      chk("wrap_idle.ready", word_ready, 1'b1);
`ifdef WORD_LOADER_STATS_EN
      chk("stats_three", word_count, 16'd3);
`endif

      // word_valid held high; match_done delayed 10 cycles
      word = 24'h000041; base_addr = 4'd9; word_valid = 1'b1;
      step();
      wcyc("hold_c1", 1'b1, 4'd9,  8'h41, 1'b0, 1'b0);
      wcyc("hold_c2", 1'b1, 4'd10, 8'h00, 1'b0, 1'b0);
      wcyc("hold_c3", 1'b0, 4'd10, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         chk("hold_wait.ready", word_ready, 1'b0);
         chk("hold_wait.cs",    sram_cs,    1'b0);
         step();
      end
      match_done = 1'b1;
      word = 24'h7a7978; base_addr = 4'd2;
      step();
      match_done = 1'b0;
      chk("hold_idle.ready", word_ready, 1'b1);
      chk("hold_idle.cs",    sram_cs,    1'b0);
      step();
      word_valid = 1'b0;
      wcyc("second_c1", 1'b1, 4'd2, 8'h78, 1'b0, 1'b0);
      wcyc("second_c2", 1'b1, 4'd3, 8'h79, 1'b0, 1'b0);
      wcyc("second_c3", 1'b1, 4'd4, 8'h7a, 1'b0, 1'b0);
      wcyc("second_c4", 1'b1, 4'd5, 8'h00, 1'b0, 1'b0);
      wcyc("second_c5", 1'b0, 4'd5, 8'h00, 1'b1, 1'b0);
      match_done = 1'b1;
      step();
      match_done = 1'b0;

      // Reset pulsed during the second WRITE cycle
      word = 24'h746163; base_addr = 4'd0; word_valid = 1'b1;
      step();
      word_valid = 1'b0;
      wcyc("rst_c1", 1'b1, 4'd0, 8'h63, 1'b0, 1'b0);
      chk("rst_c2.cs",   sram_cs,   1'b1);
      chk("rst_c2.addr", sram_addr, 4'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midload");
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("post_rst.done",  load_done,  1'b0);
         chk("post_rst.cs",    sram_cs,    1'b0);
         chk("post_rst.ready", word_ready, 1'b1);
         step();
      end
`ifdef WORD_LOADER_STATS_EN
      chk("stats_reset", word_count, 16'd0);
`endif

      // NUL in char 0: the first write is the terminator
      word = 24'h616200; base_addr = 4'd4; word_valid = 1'b1;
      step();
      word_valid = 1'b0;
      wcyc("nul0_c1", 1'b1, 4'd4, 8'h00, 1'b0, 1'b0);
      wcyc("nul0_c2", 1'b0, 4'd4, 8'h00, 1'b1, 1'b0);
      chk("nul0_wait.busy", busy, 1'b1);
`ifdef WORD_LOADER_STATS_EN
      chk("stats_one", word_count, 16'd1);
`endif
      match_done = 1'b1;
      step();
      match_done = 1'b0;
      chk("nul0_idle.ready", word_ready, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
